// File: rtl/dii_packet_buffer.sv
// dii_packet_buffer: packet-aware first-word-fall-through flit FIFO for a DII channel.
// With FULLPACKET set, the head is offered only once a whole packet is stored (or the buffer is full).
module dii_packet_buffer #(
  parameter int BUF_SIZE   = 8,
  parameter bit FULLPACKET = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic                          in_last,
  input  logic [15:0]                   in_data,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic                          out_last,
  output logic [15:0]                   out_data,
  input  logic                          out_ready,
  output logic [$clog2(BUF_SIZE+1)-1:0] packet_count,
  output logic                          empty,
  output logic                          full
);
  localparam int AW = $clog2(BUF_SIZE);
  localparam int CW = $clog2(BUF_SIZE+1);
  logic [16:0]   mem [BUF_SIZE];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] flit_cnt, pkt_cnt;
  logic          wr, rd;
  assign full         = flit_cnt == CW'(BUF_SIZE);
  assign empty        = flit_cnt == '0;
  assign in_ready     = !full && !rst;
  // full term lets an oversized packet stream through instead of deadlocking
  assign out_valid    = FULLPACKET ? (pkt_cnt != '0) || full : !empty;
  assign {out_last, out_data} = mem[rd_ptr];
  assign packet_count = pkt_cnt;
  assign wr = in_valid && in_ready;
  assign rd = out_valid && out_ready;
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= {in_last, in_data};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      flit_cnt <= '0;
      pkt_cnt  <= '0;
    end else begin
      wr_ptr   <= wr_ptr + AW'(wr);
      rd_ptr   <= rd_ptr + AW'(rd);
      flit_cnt <= flit_cnt + CW'(wr) - CW'(rd);
      pkt_cnt  <= pkt_cnt + CW'(wr && in_last) - CW'(rd && out_last);
    end
endmodule

// File: tb/tb_dii_packet_buffer.sv
// tb_dii_packet_buffer: directed test of FULLPACKET=1 and FULLPACKET=0 buffers against a queue model.
module tb_dii_packet_buffer;
  localparam int N = 8;
  logic clk = 0;
  logic rst = 1;
  logic in_valid = 0, in_last = 0, out_ready = 0;
  logic [15:0] in_data = 0;
  logic fp_ir, fp_ov, fp_ol, fp_em, fp_fu;
  logic ff_ir, ff_ov, ff_ol, ff_em, ff_fu;
  logic [15:0] fp_od, ff_od;
  logic [3:0] fp_pc, ff_pc;
  int total = 0, bad = 0;
  logic [16:0] qp[$], qf[$];
  logic [15:0] log_q[$], exp_q[$];

  always #5 clk = ~clk;

  dii_packet_buffer #(.BUF_SIZE(N), .FULLPACKET(1)) u_fp (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
    .in_ready(fp_ir), .out_valid(fp_ov), .out_last(fp_ol), .out_data(fp_od),
    .out_ready(out_ready), .packet_count(fp_pc), .empty(fp_em), .full(fp_fu));

  dii_packet_buffer #(.BUF_SIZE(N), .FULLPACKET(0)) u_ff (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
    .in_ready(ff_ir), .out_valid(ff_ov), .out_last(ff_ol), .out_data(ff_od),
    .out_ready(out_ready), .packet_count(ff_pc), .empty(ff_em), .full(ff_fu));

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  function automatic int lasts(input logic [16:0] q[$]);
    int c = 0;
    foreach (q[i]) c += int'(q[i][16]);
    return c;
  endfunction

  function automatic bit ov_fp();
    return lasts(qp) != 0 || qp.size() == N;
  endfunction

  function automatic bit ov_ff();
    return qf.size() != 0;
  endfunction

  // model: reads use pre-edge head, writes only when not full
  always @(posedge clk or posedge rst)
    if (rst) begin
      qp.delete();
      qf.delete();
    end else begin
      bit wp, wf;
      wp = in_valid && qp.size() < N;
      wf = in_valid && qf.size() < N;
      if (ov_fp() && out_ready) void'(qp.pop_front());
      if (ov_ff() && out_ready) void'(qf.pop_front());
      if (wp) qp.push_back({in_last, in_data});
      if (wf) qf.push_back({in_last, in_data});
    end

  always @(negedge clk) begin
    check("fp_in_ready", 32'(fp_ir), 32'(!rst && qp.size() < N));
    check("fp_out_valid", 32'(fp_ov), 32'(!rst && ov_fp()));
    check("fp_empty", 32'(fp_em), 32'(qp.size() == 0));
    check("fp_full", 32'(fp_fu), 32'(qp.size() == N));
    check("fp_packet_count", 32'(fp_pc), 32'(lasts(qp)));
    if (fp_ov && qp.size() != 0) check("fp_head", 32'({fp_ol, fp_od}), 32'(qp[0]));
    check("ff_in_ready", 32'(ff_ir), 32'(!rst && qf.size() < N));
    check("ff_out_valid", 32'(ff_ov), 32'(!rst && ov_ff()));
    check("ff_empty", 32'(ff_em), 32'(qf.size() == 0));
    check("ff_full", 32'(ff_fu), 32'(qf.size() == N));
    check("ff_packet_count", 32'(ff_pc), 32'(lasts(qf)));
    if (ff_ov && qf.size() != 0) check("ff_head", 32'({ff_ol, ff_od}), 32'(qf[0]));
    if (fp_ov && out_ready && !rst) log_q.push_back(fp_od);
  end

  task automatic send(input logic [15:0] d, input logic l);
    bit ok = 0;
    in_valid = 1;
    in_data  = d;
    in_last  = l;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = fp_ir;
      @(posedge clk);
      #1;
    end
    if (!ok) check("send_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    @(negedge clk);
    check("rst_empty", 32'(fp_em), 1);
    check("rst_in_ready", 32'(fp_ir), 0);
    @(posedge clk);
    #1 rst = 0;
    // packet held until last flit arrives
    out_ready = 1;
    send(16'h0001, 0);
    @(negedge clk);
    check("t1_hold", 32'(fp_ov), 0);
    @(posedge clk);
    #1;
    send(16'h0002, 0);
    send(16'h0003, 1);
    @(negedge clk);
    check("t1_offer", 32'(fp_ov), 1);
    check("t1_pc", 32'(fp_pc), 1);
    check("t1_head", 32'(fp_od), 32'h0001);
    idle(5);
    for (int i = 1; i <= 3; i++) exp_q.push_back(16'(i));
    // oversized packet streams through once full
    out_ready = 0;
    fork
      for (int i = 0; i < 10; i++) send(16'h0010 + 16'(i), i == 9);
      begin
        bit seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
          @(negedge clk);
          seen = fp_fu;
        end
        check("t2_full", 32'(seen), 1);
        check("t2_in_ready", 32'(fp_ir), 0);
        check("t2_out_valid", 32'(fp_ov), 1);
        check("t2_pc", 32'(fp_pc), 0);
        idle(2);
        out_ready = 1;
      end
    join
    idle(12);
    for (int i = 0; i < 10; i++) exp_q.push_back(16'h0010 + 16'(i));
    // back-to-back single-flit packets
    out_ready = 1;
    fork
      for (int i = 0; i < 8; i++) send(16'h0020 + 16'(i), 1);
      begin
        repeat (4) @(negedge clk);
        check("t3_pc_steady", 32'(fp_pc), 1);
        @(negedge clk);
        check("t3_pc_steady2", 32'(fp_pc), 1);
      end
    join
    idle(4);
    for (int i = 0; i < 8; i++) exp_q.push_back(16'h0020 + 16'(i));
    // full: read wins, write deferred one cycle
    out_ready = 0;
    for (int i = 0; i < 8; i++) send(16'h0030 + 16'(i), i == 7);
    in_valid = 1;
    in_data = 16'h0038;
    in_last = 1;
    out_ready = 1;
    @(negedge clk);
    check("t4_no_write", 32'(fp_ir), 0);
    check("t4_full", 32'(fp_fu), 1);
    @(posedge clk);
    #1 out_ready = 0;
    @(negedge clk);
    check("t4_ready_again", 32'(fp_ir), 1);
    check("t4_not_full", 32'(fp_fu), 0);
    @(posedge clk);
    #1 in_valid = 0;
    @(negedge clk);
    check("t4_written", 32'(fp_fu), 1);
    check("t4_pc", 32'(fp_pc), 2);
    out_ready = 1;
    idle(12);
    for (int i = 0; i < 9; i++) exp_q.push_back(16'h0030 + 16'(i));
    // async reset discards stored flits
    out_ready = 0;
    for (int i = 0; i < 5; i++) send(16'h0040 + 16'(i), i == 2);
    #2 rst = 1;
    #1;
    check("t5_empty", 32'(fp_em), 1);
    check("t5_out_valid", 32'(fp_ov), 0);
    check("t5_in_ready", 32'(fp_ir), 0);
    check("t5_pc", 32'(fp_pc), 0);
    @(posedge clk);
    #1 rst = 0;
    out_ready = 1;
    send(16'h0050, 0);
    send(16'h0051, 1);
    idle(5);
    exp_q.push_back(16'h0050);
    exp_q.push_back(16'h0051);
    // plain FIFO mode offers immediately
    out_ready = 0;
    send(16'hBEEF, 0);
    @(negedge clk);
    check("t6_out_valid", 32'(ff_ov), 1);
    check("t6_out_data", 32'(ff_od), 32'hBEEF);
    check("t6_pc", 32'(ff_pc), 0);
    check("t6_fp_hold", 32'(fp_ov), 0);
    check("log_len", 32'(log_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i])
      if (i < log_q.size()) check("log_data", 32'(log_q[i]), 32'(exp_q[i]));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
